// File: rtl/input_rd_ctrl.sv
// rtl/input_rd_ctrl.sv - input SRAM read controller with diagonal skew into the systolic array rows
module input_rd_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int SYS_ROW    = 16,
    parameter int MEM_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start_i,
    input  logic [ADDR_WIDTH-1:0]         base_addr_i,
    input  logic [DATA_WIDTH-1:0]         num_row_i,
    output logic                          mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0]         mem_rd_addr_o,
    input  logic [SYS_ROW*DATA_WIDTH-1:0] mem_rd_data_i,
    output logic [SYS_ROW*DATA_WIDTH-1:0] sys_in_data_o,
    output logic [SYS_ROW-1:0]            sys_in_valid_o,
    output logic                          busy_o,
    output logic                          done_o
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    // Cycles spent in DRAIN before done: read latency plus the deepest skew lane.
    localparam logic [DATA_WIDTH-1:0] DRAIN_LEN = DATA_WIDTH'(MEM_LAT + SYS_ROW);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   num_q, num_d;
    logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    rd_en_q, rd_en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [MEM_LAT-1:0]      tag_q;
    logic                    data_ok;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            num_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (start_i && num_row_i != '0) begin
                    state_d = READ;
                    num_d   = num_row_i;
                    cnt_d   = DATA_WIDTH'(1);
                    addr_d  = base_addr_i;
                end
            end
            READ: begin
                if (cnt_q == num_q) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + DATA_WIDTH'(1);
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LEN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DATA_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered.
    always_comb begin
        rd_en_d = (state_d == READ);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DRAIN && cnt_d == DRAIN_LEN) ||
                  (state_q == IDLE && start_i && num_row_i == '0);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= rd_en_q;
            for (int j = 1; j < MEM_LAT; j++) tag_q[j] <= tag_q[j-1];
        end
    end

    assign data_ok = tag_q[MEM_LAT-1];

    // Lane i runs through i+1 stages; zeroed data rides along with invalid slots.
    for (genvar i = 0; i < SYS_ROW; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] dat_q [i+1];
        logic [i:0]            vld_q;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                vld_q <= '0;
                for (int j = 0; j <= i; j++) dat_q[j] <= '0;
            end else begin
                vld_q[0] <= data_ok;
                dat_q[0] <= data_ok ? mem_rd_data_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int j = 1; j <= i; j++) begin
                    vld_q[j] <= vld_q[j-1];
                    dat_q[j] <= dat_q[j-1];
                end
            end
        end

        assign sys_in_valid_o[i]                         = vld_q[i];
        assign sys_in_data_o[i*DATA_WIDTH +: DATA_WIDTH] = dat_q[i];
    end

    assign mem_rd_en_o   = rd_en_q;
    assign mem_rd_addr_o = addr_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_input_rd_ctrl.sv
// tb/tb_input_rd_ctrl.sv - randomized bench for input_rd_ctrl against a cycle-window transfer model
module tb_input_rd_ctrl;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int R  = 4;
    localparam int L  = 1;
    localparam int W  = R * DW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [DW-1:0] num_row_i = '0;
    logic          mem_rd_en_o;
    logic [AW-1:0] mem_rd_addr_o;
    logic [W-1:0]  mem_rd_data_i;
    logic [W-1:0]  sys_in_data_o;
    logic [R-1:0]  sys_in_valid_o;
    logic          busy_o;
    logic          done_o;

    input_rd_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .SYS_ROW    (R),
        .MEM_LAT    (L)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start_i        (start_i),
        .base_addr_i    (base_addr_i),
        .num_row_i      (num_row_i),
        .mem_rd_en_o    (mem_rd_en_o),
        .mem_rd_addr_o  (mem_rd_addr_o),
        .mem_rd_data_i  (mem_rd_data_i),
        .sys_in_data_o  (sys_in_data_o),
        .sys_in_valid_o (sys_in_valid_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    int unsigned seed_w;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Word k lane i = {addr,lane} mixed with a run seed so lanes and words all differ.
    function automatic logic [W-1:0] mem_word(input logic [AW-1:0] a);
        logic [W-1:0] w;
        for (int i = 0; i < R; i++)
            w[i*DW +: DW] = DW'((32'(a) << 4 | 32'(i)) ^ seed_w);
        return w;
    endfunction

    // SRAM with MEM_LAT cycles of read latency; junk on the bus when not reading.
    logic [W-1:0] lat_q [L];
    always @(posedge clk) begin
        lat_q[0] <= mem_rd_en_o ? mem_word(mem_rd_addr_o) : {$urandom, $urandom};
        for (int j = 1; j < L; j++) lat_q[j] <= lat_q[j-1];
    end
    assign mem_rd_data_i = lat_q[L-1];

    typedef struct {
        bit            act;
        int            t0;
        int            n;
        logic [AW-1:0] base;
    } txn_t;

    txn_t cur, prv;

    logic          x_en, x_busy, x_done;
    logic [AW-1:0] x_addr;
    logic [R-1:0]  x_v;
    logic [W-1:0]  x_data;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int busy_end(input txn_t tx);
        return (tx.n > 0) ? tx.n + L + R + 1 : 0;
    endfunction

    task automatic accum(input txn_t tx, input int t);
        int c;
        int k;
        logic [W-1:0] w;
        if (!tx.act) return;
        c = t - tx.t0;
        if (c == ((tx.n > 0) ? tx.n + L + R + 1 : 1)) x_done = 1'b1;
        if (tx.n > 0 && c >= 1 && c <= busy_end(tx)) x_busy = 1'b1;
        if (c >= 1 && c <= tx.n) begin
            x_en   = 1'b1;
            x_addr = tx.base + AW'(c - 1);
        end
        for (int i = 0; i < R; i++) begin
            k = c - 2 - L - i;
            if (k >= 0 && k < tx.n) begin
                x_v[i] = 1'b1;
                w = mem_word(tx.base + AW'(k));
                x_data[i*DW +: DW] = w[i*DW +: DW];
            end
        end
    endtask

    task automatic check_outputs();
        x_en = 0; x_busy = 0; x_done = 0; x_addr = '0; x_v = '0; x_data = '0;
        accum(prv, cyc);
        accum(cur, cyc);
        check("rd_en", W'(mem_rd_en_o), W'(x_en));
        if (x_en) check("rd_addr", W'(mem_rd_addr_o), W'(x_addr));
        check("valid", W'(sys_in_valid_o), W'(x_v));
        check("data", sys_in_data_o, x_data);
        check("busy", W'(busy_o), W'(x_busy));
        check("done", W'(done_o), W'(x_done));
    endtask

    // Called at a negedge: check this cycle's outputs, then drive this cycle's inputs.
    task automatic step(input bit s, input logic [AW-1:0] b, input int n, input bit rn);
        check_outputs();
        start_i     = s;
        base_addr_i = b;
        num_row_i   = DW'(n);
        rstn        = rn;
        if (!rn) begin
            cur.act = 0;
            prv.act = 0;
        end else if (s && (!cur.act || cyc > cur.t0 + busy_end(cur))) begin
            prv = cur;
            cur = '{1'b1, cyc, int'(DW'(n)), b};
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, '0, 0, 1'b1);
    endtask

    initial begin
        seed_w  = $urandom;
        cur.act = 0;
        prv.act = 0;
        @(negedge clk);
        step(1'b0, '0, 0, 1'b0);
        step(1'b0, '0, 0, 1'b0);
        check("rst_addr", W'(mem_rd_addr_o), W'(0));

        step(1'b1, 16'h0010, 3, 1'b1);
        idle(12);

        step(1'b1, 16'h0040, 0, 1'b1);
        idle(4);

        step(1'b1, 16'hFFFE, 4, 1'b1);
        idle(12);

        step(1'b1, 16'h0010, 3, 1'b1);
        idle(3);
        step(1'b1, 16'h0055, 7, 1'b1);
        idle(4);
        step(1'b1, 16'h0066, 5, 1'b1);
        step(1'b1, 16'h0020, 3, 1'b1);
        idle(12);

        step(1'b1, 16'h0010, 3, 1'b1);
        idle(3);
        step(1'b0, '0, 0, 1'b0);
        idle(2);
        step(1'b1, 16'h0010, 3, 1'b1);
        idle(12);

        step(1'b1, 16'hFF80, 300, 1'b1);
        idle(310);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0)
                step(1'b0, '0, 0, 1'b0);
            else
                step($urandom_range(0, 5) == 0, AW'($urandom), $urandom_range(0, 7), 1'b1);
        end
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
